// File: rtl/mem_copy_master.sv
// Word-at-a-time memory copy engine: reads a source word, writes it to the destination,
// and repeats for len words over a single-ported memory with zero read latency.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; ADDR/WE parked at 0
// READ  | ADDR = source pointer, RD captured into data register
// WRITE | ADDR = destination pointer, WE = 1, WD = data register
// DONE  | one-cycle done pulse, then back to IDLE
module mem_copy_master #(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  src_addr,
    input  logic [ADDR_WIDTH-1:0]  dst_addr,
    input  logic [15:0]            len,
    output logic                   WE,
    output logic [ADDR_WIDTH-1:0]  ADDR,
    output logic [BYTE_SIZE*8-1:0] WD,
    input  logic [BYTE_SIZE*8-1:0] RD,
    output logic                   busy,
    output logic                   done,
    output logic [15:0]            count
);

    localparam int DW = BYTE_SIZE * 8;
    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BYTE_SIZE);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_src_ptr;
    logic [ADDR_WIDTH-1:0] r_dst_ptr;
    logic [15:0]           r_remaining;
    logic [15:0]           r_count;
    logic [DW-1:0]         r_data;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_busy;
    logic                  r_done;

    // Outputs are registered alongside the state so each one reflects the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_src_ptr   <= '0;
            r_dst_ptr   <= '0;
            r_remaining <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_src_ptr   <= src_addr;
                        r_dst_ptr   <= dst_addr;
                        r_remaining <= len;
                        r_count     <= '0;
                        if (len != 16'd0) begin
                            r_state <= READ;
                            r_busy  <= 1'b1;
                            r_addr  <= src_addr;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    r_data    <= RD;
                    r_src_ptr <= r_src_ptr + STEP;
                    r_state   <= WRITE;
                    r_addr    <= r_dst_ptr;
                    r_we      <= 1'b1;
                end
                WRITE: begin
                    r_dst_ptr   <= r_dst_ptr + STEP;
                    r_remaining <= r_remaining - 16'd1;
                    r_count     <= r_count + 16'd1;
                    r_we        <= 1'b0;
                    if (r_remaining == 16'd1) begin
                        r_state <= DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_addr  <= '0;
                    end else begin
                        // Source pointer was already advanced during READ.
                        r_state <= READ;
                        r_addr  <= r_src_ptr;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_we    <= 1'b0;
                    r_addr  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign WE    = r_we;
    assign ADDR  = r_addr;
    assign WD    = r_data;
    assign busy  = r_busy;
    assign done  = r_done;
    assign count = r_count;

endmodule

// File: tb/tb_mem_copy_master.sv
// Directed bench for mem_copy_master: a 32-bit-address instance and a 12-bit-address
// instance, each attached to a combinational-read word memory.
module tb_mem_copy_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
    logic        WE;
    logic [31:0] ADDR, WD, RD;
    logic        busy, done;
    logic [15:0] count;

    logic        s_start;
    logic [11:0] s_src, s_dst;
    logic [15:0] s_len;
    logic        s_we;
    logic [11:0] s_addr;
    logic [31:0] s_wd, s_rd;
    logic        s_busy, s_done;
    logic [15:0] s_count;

    mem_copy_master #(.BYTE_SIZE(4), .ADDR_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .WE(WE), .ADDR(ADDR), .WD(WD), .RD(RD), .busy(busy), .done(done),
        .count(count)
    );

    mem_copy_master #(.BYTE_SIZE(4), .ADDR_WIDTH(12)) dut_s (
        .clk(clk), .reset(reset), .start(s_start), .src_addr(s_src), .dst_addr(s_dst),
        .len(s_len), .WE(s_we), .ADDR(s_addr), .WD(s_wd), .RD(s_rd), .busy(s_busy),
        .done(s_done), .count(s_count)
    );

    logic [31:0] mem   [0:1023];
    logic [31:0] mem_s [0:1023];
    logic        pl_we, pl_sel, pl_clr;
    logic [9:0]  pl_idx;
    logic [31:0] pl_val;

    assign RD   = mem[ADDR[11:2]];
    assign s_rd = mem_s[s_addr[11:2]];

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
        end else if (pl_we && !pl_sel) begin
            mem[pl_idx] <= pl_val;
        end else if (WE) begin
            mem[ADDR[11:2]] <= WD;
        end
    end

    always @(posedge clk) begin
        if (pl_clr) begin
            for (int i = 0; i < 1024; i++) mem_s[i] <= 32'h0;
        end else if (pl_we && pl_sel) begin
            mem_s[pl_idx] <= pl_val;
        end else if (s_we) begin
            mem_s[s_addr[11:2]] <= s_wd;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] addr_log [0:31];

    task automatic preload(input logic sel, input logic [9:0] idx, input logic [31:0] v);
        @(negedge clk);
        pl_sel = sel; pl_idx = idx; pl_val = v; pl_we = 1'b1;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic clear_mem();
        @(negedge clk);
        pl_clr = 1'b1;
        @(negedge clk);
        pl_clr = 1'b0;
    endtask

    task automatic run_main(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                            input int ncyc, input bit hold, output int dc, output int nd,
                            output int nw, output logic [63:0] bm);
        dc = -1; nd = 0; nw = 0; bm = '0;
        @(negedge clk);
        src_addr = s; dst_addr = d; len = l; start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= ncyc && c < 32; c++) begin
            @(negedge clk);
            addr_log[c] = ADDR;
            if (busy) bm[c] = 1'b1;
            if (WE) nw++;
            if (done) begin
                nd++;
                if (dc < 0) dc = c;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        n_vec++; if ({WE, busy, done} !== 3'b000) begin n_err++; $display("FAIL reset_ctl got %b want 000", {WE, busy, done}); end
        n_vec++; if (ADDR !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", ADDR); end
        n_vec++; if (WD !== 32'h0) begin n_err++; $display("FAIL reset_wd got %h want 0", WD); end
        n_vec++; if (count !== 16'd0) begin n_err++; $display("FAIL reset_count got %0d want 0", count); end
        n_vec++; if ({s_we, s_busy, s_done} !== 3'b000) begin n_err++; $display("FAIL reset_small got %b want 000", {s_we, s_busy, s_done}); end
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++; if ({WE, busy, done} !== 3'b000) begin n_err++; $display("FAIL idle_nostart got %b want 000", {WE, busy, done}); end
    endtask

    task automatic test_basic();
        int dc, nd, nw;
        logic [63:0] bm;
        clear_mem();
        preload(1'b0, 10'd0, 32'h11111111);
        preload(1'b0, 10'd1, 32'h22222222);
        preload(1'b0, 10'd2, 32'h33333333);
        run_main(32'h0, 32'h100, 16'd3, 9, 1'b0, dc, nd, nw, bm);
        n_vec++; if (dc !== 7) begin n_err++; $display("FAIL basic_done_cycle got %0d want 7", dc); end
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL basic_done_pulses got %0d want 1", nd); end
        n_vec++; if (nw !== 3) begin n_err++; $display("FAIL basic_writes got %0d want 3", nw); end
        n_vec++; if (bm !== 64'h7E) begin n_err++; $display("FAIL basic_busy got %h want 7e", bm); end
        n_vec++; if (count !== 16'd3) begin n_err++; $display("FAIL basic_count got %0d want 3", count); end
        n_vec++; if (mem[10'h40] !== 32'h11111111) begin n_err++; $display("FAIL basic_w0 got %h want 11111111", mem[10'h40]); end
        n_vec++; if (mem[10'h41] !== 32'h22222222) begin n_err++; $display("FAIL basic_w1 got %h want 22222222", mem[10'h41]); end
        n_vec++; if (mem[10'h42] !== 32'h33333333) begin n_err++; $display("FAIL basic_w2 got %h want 33333333", mem[10'h42]); end
        n_vec++; if (addr_log[1] !== 32'h0) begin n_err++; $display("FAIL basic_addr_c1 got %h want 0", addr_log[1]); end
        n_vec++; if (addr_log[2] !== 32'h100) begin n_err++; $display("FAIL basic_addr_c2 got %h want 100", addr_log[2]); end
        n_vec++; if (addr_log[3] !== 32'h4) begin n_err++; $display("FAIL basic_addr_c3 got %h want 4", addr_log[3]); end
        n_vec++; if (addr_log[6] !== 32'h108) begin n_err++; $display("FAIL basic_addr_c6 got %h want 108", addr_log[6]); end
        n_vec++; if (addr_log[7] !== 32'h0) begin n_err++; $display("FAIL basic_addr_done got %h want 0", addr_log[7]); end
        repeat (3) @(negedge clk);
        n_vec++; if (count !== 16'd3) begin n_err++; $display("FAIL basic_count_hold got %0d want 3", count); end
    endtask

    task automatic test_len0();
        int dc, nd, nw;
        logic [63:0] bm;
        run_main(32'h0, 32'h100, 16'd0, 3, 1'b0, dc, nd, nw, bm);
        n_vec++; if (dc !== 1) begin n_err++; $display("FAIL len0_done_cycle got %0d want 1", dc); end
        n_vec++; if (nw !== 0) begin n_err++; $display("FAIL len0_writes got %0d want 0", nw); end
        n_vec++; if (bm !== 64'h0) begin n_err++; $display("FAIL len0_busy got %h want 0", bm); end
        n_vec++; if (count !== 16'd0) begin n_err++; $display("FAIL len0_count got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        int dc, nd, nw;
        logic [63:0] bm;
        bit got;
        clear_mem();
        preload(1'b0, 10'd0, 32'hA0A0A0A0);
        preload(1'b0, 10'd1, 32'hA1A1A1A1);
        run_main(32'h0, 32'h100, 16'd2, 7, 1'b1, dc, nd, nw, bm);
        start = 1'b0;
        n_vec++; if (dc !== 5) begin n_err++; $display("FAIL b2b_done_cycle got %0d want 5", dc); end
        n_vec++; if (nd !== 1) begin n_err++; $display("FAIL b2b_done_pulses got %0d want 1", nd); end
        n_vec++; if (nw !== 2) begin n_err++; $display("FAIL b2b_writes got %0d want 2", nw); end
        n_vec++; if (bm !== 64'h9E) begin n_err++; $display("FAIL b2b_busy got %h want 9e", bm); end
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        n_vec++; if (got !== 1'b1) begin n_err++; $display("FAIL b2b_restart_done got %b want 1", got); end
        n_vec++; if (count !== 16'd2) begin n_err++; $display("FAIL b2b_count got %0d want 2", count); end
        n_vec++; if (mem[10'h41] !== 32'hA1A1A1A1) begin n_err++; $display("FAIL b2b_w1 got %h want a1a1a1a1", mem[10'h41]); end
    endtask

    task automatic test_input_latch();
        int dc;
        clear_mem();
        preload(1'b0, 10'd0, 32'hC0C0C0C0);
        preload(1'b0, 10'd1, 32'hC1C1C1C1);
        @(negedge clk);
        src_addr = 32'h0; dst_addr = 32'h200; len = 16'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; src_addr = 32'h40; dst_addr = 32'h300; len = 16'd5;
        dc = -1;
        for (int c = 1; c <= 12 && dc < 0; c++) begin
            @(negedge clk);
            if (done) dc = c;
        end
        n_vec++; if (dc !== 5) begin n_err++; $display("FAIL latch_done_cycle got %0d want 5", dc); end
        n_vec++; if (count !== 16'd2) begin n_err++; $display("FAIL latch_count got %0d want 2", count); end
        n_vec++; if (mem[10'h80] !== 32'hC0C0C0C0) begin n_err++; $display("FAIL latch_w0 got %h want c0c0c0c0", mem[10'h80]); end
        n_vec++; if (mem[10'h81] !== 32'hC1C1C1C1) begin n_err++; $display("FAIL latch_w1 got %h want c1c1c1c1", mem[10'h81]); end
        n_vec++; if (mem[10'hC0] !== 32'h0) begin n_err++; $display("FAIL latch_newdst got %h want 0", mem[10'hC0]); end
    endtask

    task automatic test_reset_midcopy();
        int nd;
        clear_mem();
        for (int i = 0; i < 4; i++) begin
            preload(1'b0, 10'(i), 32'hD0D0D000 + 32'(i));
            preload(1'b0, 10'(16'h40 + i), 32'hEEEE0000 + 32'(i));
        end
        @(negedge clk);
        src_addr = 32'h0; dst_addr = 32'h100; len = 16'd4; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        n_vec++; if ({WE, ADDR} !== {1'b1, 32'h104}) begin n_err++; $display("FAIL rst_pre got we=%b addr=%h want we=1 addr=104", WE, ADDR); end
        reset = 1'b0;
        #1;
        n_vec++; if ({WE, busy} !== 2'b00) begin n_err++; $display("FAIL rst_immediate got %b want 00", {WE, busy}); end
        n_vec++; if (ADDR !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", ADDR); end
        nd = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (done) nd++;
        end
        n_vec++; if (nd !== 0) begin n_err++; $display("FAIL rst_no_done got %0d want 0", nd); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy got %b want 0", busy); end
        n_vec++; if (mem[10'h40] !== 32'hD0D0D000) begin n_err++; $display("FAIL rst_w0 got %h want d0d0d000", mem[10'h40]); end
        n_vec++; if (mem[10'h41] !== 32'hEEEE0001) begin n_err++; $display("FAIL rst_w1 got %h want eeee0001", mem[10'h41]); end
        n_vec++; if (mem[10'h42] !== 32'hEEEE0002) begin n_err++; $display("FAIL rst_w2 got %h want eeee0002", mem[10'h42]); end
    endtask

    task automatic test_overlap();
        int dc, nd, nw;
        logic [63:0] bm;
        clear_mem();
        preload(1'b0, 10'd0, 32'hAAAAAAAA);
        preload(1'b0, 10'd1, 32'hBBBBBBBB);
        preload(1'b0, 10'd2, 32'hCCCCCCCC);
        run_main(32'h0, 32'h4, 16'd2, 7, 1'b0, dc, nd, nw, bm);
        n_vec++; if (dc !== 5) begin n_err++; $display("FAIL ovl_done_cycle got %0d want 5", dc); end
        n_vec++; if (mem[10'd0] !== 32'hAAAAAAAA) begin n_err++; $display("FAIL ovl_w0 got %h want aaaaaaaa", mem[10'd0]); end
        n_vec++; if (mem[10'd1] !== 32'hAAAAAAAA) begin n_err++; $display("FAIL ovl_w1 got %h want aaaaaaaa", mem[10'd1]); end
        n_vec++; if (mem[10'd2] !== 32'hAAAAAAAA) begin n_err++; $display("FAIL ovl_w2 got %h want aaaaaaaa", mem[10'd2]); end
    endtask

    task automatic test_wrap();
        int dc;
        clear_mem();
        preload(1'b1, 10'h3FF, 32'hAAAA0001);
        preload(1'b1, 10'h000, 32'hBBBB0002);
        @(negedge clk);
        s_src = 12'hFFC; s_dst = 12'h200; s_len = 16'd2; s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        dc = -1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (c == 1) begin
                n_vec++; if (s_addr !== 12'hFFC) begin n_err++; $display("FAIL wrap_read1 got %h want ffc", s_addr); end
            end
            if (c == 3) begin
                n_vec++; if (s_addr !== 12'h000) begin n_err++; $display("FAIL wrap_read2 got %h want 000", s_addr); end
            end
            if (s_done && dc < 0) dc = c;
        end
        n_vec++; if (dc !== 5) begin n_err++; $display("FAIL wrap_done_cycle got %0d want 5", dc); end
        n_vec++; if (mem_s[10'h80] !== 32'hAAAA0001) begin n_err++; $display("FAIL wrap_w0 got %h want aaaa0001", mem_s[10'h80]); end
        n_vec++; if (mem_s[10'h81] !== 32'hBBBB0002) begin n_err++; $display("FAIL wrap_w1 got %h want bbbb0002", mem_s[10'h81]); end
        n_vec++; if (s_count !== 16'd2) begin n_err++; $display("FAIL wrap_count got %0d want 2", s_count); end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        s_start = 1'b0; s_src = '0; s_dst = '0; s_len = '0;
        pl_we = 1'b0; pl_sel = 1'b0; pl_clr = 1'b0; pl_idx = '0; pl_val = '0;
        test_reset();
        test_basic();
        test_len0();
        test_back_to_back();
        test_input_latch();
        test_reset_midcopy();
        test_overlap();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_copy_master.md
MEM_COPY_MASTER -- requirements
Module: mem_copy_master

Interface
REQ-001 Parameter BYTE_SIZE, default 4, sets the bytes per memory word; the data width is BYTE_SIZE*8.
REQ-002 Parameter ADDR_WIDTH, default 32, sets the byte-address width.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 start  input  1  request a copy; sampled only in IDLE.
REQ-006 src_addr  input  ADDR_WIDTH  source byte address of the first word.
REQ-007 dst_addr  input  ADDR_WIDTH  destination byte address of the first word.
REQ-008 len  input  16  number of words to copy.
REQ-009 WE  output  1  memory write enable.
REQ-010 ADDR  output  ADDR_WIDTH  memory byte address.
REQ-011 WD  output  BYTE_SIZE*8  memory write data.
REQ-012 RD  input  BYTE_SIZE*8  memory read data; combinational from ADDR with no read latency.
REQ-013 busy  output  1  high while a copy is in progress.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 count  output  16  number of words written in the current or most recent copy.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, READ, WRITE and DONE.
REQ-017 IDLE with start=1: on the edge, latch src_ptr=src_addr, dst_ptr=dst_addr, remaining=len and count=0.
- Next state is READ if len!=0, else DONE.
REQ-018 IDLE with start=0: remain in IDLE.
REQ-019 READ drives ADDR=src_ptr and WE=0.
- On the edge, capture RD into data_reg, add BYTE_SIZE to src_ptr, go to WRITE.
REQ-020 WRITE drives ADDR=dst_ptr, WD=data_reg and WE=1.
- On the edge: add BYTE_SIZE to dst_ptr, decrement remaining, increment count.
- Next state is DONE if remaining was 1, else READ.
REQ-021 DONE asserts done=1 for exactly one cycle, then returns to IDLE.
REQ-022 busy SHALL be 1 in READ and WRITE and 0 in IDLE and DONE.
REQ-023 ADDR SHALL be 0 and WE SHALL be 0 in IDLE and DONE.
- WD holds data_reg in every state.
REQ-024 Pointer arithmetic is modulo 2^ADDR_WIDTH.
- An address past the top wraps to 0 without an error indication.
REQ-025 start asserted in READ, WRITE or DONE is ignored; it is not queued.
REQ-026 Inputs src_addr, dst_addr and len are used only at the start edge; later changes have no effect on the active copy.
REQ-027 The copy is forward only, lowest address first.
- Overlapping regions are not detected.
- With dst_addr > src_addr and an overlap, already-overwritten source words are re-read as written.
REQ-028 A copy of len=N words SHALL take 2N cycles in READ/WRITE.
- done is high in cycle 2N+1 after the start edge.
- With len=0, done is high in cycle 1.
REQ-029 count holds its final value after DONE until the next accepted start clears it.

Reset
REQ-030 While reset=0, outputs are forced immediately, independent of clk: state=IDLE, WE=0, ADDR=0, WD=0, busy=0, done=0, count=0.
- Internal pointers, remaining and data_reg are also cleared to 0.
REQ-031 Reset asserted mid-copy abandons the copy with no done pulse.
- A WRITE in progress is not committed if reset falls before the clock edge.
REQ-032 After reset is released, the first edge behaves as IDLE per REQ-017/REQ-018.

Verification
REQ-033 Preload memory words 0x11111111, 0x22222222 and 0x33333333 at bytes 0x00, 0x04 and 0x08.
- Stimulus: start with src=0x00, dst=0x100, len=3.
- Required: bytes 0x100, 0x104 and 0x108 hold those words; done pulses in cycle 7; count=3; busy high for cycles 1-6.
REQ-034 Stimulus: len=0 start.
- Required: no WE pulse; done=1 in cycle 1; count=0; busy never high.
REQ-035 Stimulus: start re-asserted every cycle during a len=2 copy.
- Required: exactly 2 writes and a single done pulse; the copy restarts only on the start after DONE.
REQ-036 Stimulus: drop reset during the WRITE of word 2 of a len=4 copy.
- Required: WE=0 and busy=0 immediately; no done pulse; destination word 2 is unmodified.
REQ-037 Stimulus: ADDR_WIDTH=12, src=0xFFC, dst=0x200, len=2.
- Required: second read is at 0x000; destination bytes 0x200 and 0x204 hold mem[0xFFC] and mem[0x000].
REQ-038 Overlap case. Preload A, B, C at 0x00, 0x04 and 0x08.
- Stimulus: src=0x00, dst=0x04, len=2.
- Required: result is A, A, A at 0x00, 0x04 and 0x08 (forward-copy semantics).
